// File: rtl/q_pkg.sv
// Shared defaults and saturation limits for the Q-value update pipeline.
// The fixed-point format defaults to Q16.16 in 32 bits.
package q_pkg;

  localparam int Q_DATA_WIDTH = 32;
  localparam int Q_FRAC_BITS  = 16;
  localparam int Q_ID_WIDTH   = 8;

  localparam logic [31:0] Q_ALPHA_RST = 32'h0000_8000;
  localparam logic [31:0] Q_GAMMA_RST = 32'h0000_E666;

  localparam logic [Q_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(Q_DATA_WIDTH-1){1'b1}}};
  localparam logic [Q_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(Q_DATA_WIDTH-1){1'b0}}};

  // Payload at the default width; the top re-declares it with its own parameters.
  typedef struct packed {
    logic [Q_DATA_WIDTH-1:0] q;
    logic [Q_DATA_WIDTH-1:0] r;
    logic [Q_DATA_WIDTH-1:0] x;
    logic [Q_DATA_WIDTH-1:0] alpha;
    logic [Q_ID_WIDTH-1:0]   id;
    logic                    sat;
  } q_stage_t;

endpackage

// File: rtl/fx_mul_sat.sv
// Signed fixed-point multiply: full-width product, round half up, arithmetic
// shift by FRAC_BITS, then clamp to DATA_WIDTH with a saturation flag.
module fx_mul_sat #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  sat
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0] a_x_s;
  logic signed [PW-1:0] b_x_s;
  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] shr_s;

  // Product, rounding and clamp; the result fits only if the upper bits are a pure sign extension.
  always_comb begin
    a_x_s  = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    b_x_s  = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    prod_s = a_x_s * b_x_s;
    shr_s  = (prod_s + RND) >>> FRAC_BITS;
    if (shr_s[PW-1:DATA_WIDTH-1] == {(DATA_WIDTH+1){shr_s[PW-1]}}) begin
      y   = shr_s[DATA_WIDTH-1:0];
      sat = 1'b0;
    end else if (shr_s[PW-1]) begin
      y   = S_MIN;
      sat = 1'b1;
    end else begin
      y   = S_MAX;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/q_update_pipe.sv
// Q-value update pipeline: Q_new = Q + alpha*(r + gamma*maxQ - Q), four register
// stages advanced by one global enable, saturating arithmetic, in-order results.
module q_update_pipe
  import q_pkg::*;
#(
  parameter int                    DATA_WIDTH = Q_DATA_WIDTH,
  parameter int                    FRAC_BITS  = Q_FRAC_BITS,
  parameter int                    ID_WIDTH   = Q_ID_WIDTH,
  parameter logic [DATA_WIDTH-1:0] ALPHA_RST  = DATA_WIDTH'(Q_ALPHA_RST),
  parameter logic [DATA_WIDTH-1:0] GAMMA_RST  = DATA_WIDTH'(Q_GAMMA_RST)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [DATA_WIDTH-1:0] cfg_alpha,
  input  logic [DATA_WIDTH-1:0] cfg_gamma,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [ID_WIDTH-1:0]   i_id,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic [DATA_WIDTH-1:0] i_max_q,
  input  logic [DATA_WIDTH-1:0] i_rt,
  input  logic                  i_done,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [ID_WIDTH-1:0]   o_id,
  output logic [DATA_WIDTH-1:0] o_q_new,
  output logic                  o_sat
);

  localparam int AW = DATA_WIDTH + 2;
  localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // x holds gm after S1, td after S2 and delta after S3.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] x;
    logic [ID_WIDTH-1:0]   id;
    logic                  sat;
  } stage_t;

  function automatic logic [AW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{2{v[DATA_WIDTH-1]}}, v};
  endfunction

  // Returns {saturated, clamped value}.
  function automatic logic [DATA_WIDTH:0] sat_narrow(input logic [AW-1:0] v);
    logic [DATA_WIDTH:0] res;
    if (v[AW-1:DATA_WIDTH-1] == {3{v[AW-1]}}) begin
      res = {1'b0, v[DATA_WIDTH-1:0]};
    end else if (v[AW-1]) begin
      res = {1'b1, S_MIN};
    end else begin
      res = {1'b1, S_MAX};
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] alpha_r, gamma_r;
  logic [DATA_WIDTH-1:0] r1_r, a1_r, a2_r;
  logic                  v1_r, v2_r, v3_r;
  stage_t                s1_r, s2_r, s3_r;
  stage_t                s1_s, s2_s, s3_s;
  logic                  en_s;
  logic [DATA_WIDTH-1:0] gm_s, delta_s;
  logic                  gm_sat_s, delta_sat_s;
  logic [DATA_WIDTH:0]   td_s, qn_s;

  assign en_s    = o_ready | ~o_valid;
  assign i_ready = en_s;

  fx_mul_sat #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_gm (
    .a(gamma_r), .b(i_max_q), .y(gm_s), .sat(gm_sat_s)
  );

  fx_mul_sat #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_delta (
    .a(a2_r), .b(s2_r.x), .y(delta_s), .sat(delta_sat_s)
  );

  // Next-stage payloads; the saturation flag accumulates down the pipe.
  always_comb begin
    s1_s    = '0;
    s1_s.q  = i_q;
    s1_s.id = i_id;
    if (i_done) begin
      s1_s.x   = {DATA_WIDTH{1'b0}};
      s1_s.sat = 1'b0;
    end else begin
      s1_s.x   = gm_s;
      s1_s.sat = gm_sat_s;
    end
    td_s     = sat_narrow(sext(r1_r) + sext(s1_r.x) - sext(s1_r.q));
    s2_s     = s1_r;
    s2_s.x   = td_s[DATA_WIDTH-1:0];
    s2_s.sat = s1_r.sat | td_s[DATA_WIDTH];
    s3_s     = s2_r;
    s3_s.x   = delta_s;
    s3_s.sat = s2_r.sat | delta_sat_s;
    qn_s     = sat_narrow(sext(s3_r.q) + sext(s3_r.x));
  end

  // Run-time learning rate and discount factor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alpha_r <= ALPHA_RST;
      gamma_r <= GAMMA_RST;
    end else if (cfg_we) begin
      alpha_r <= cfg_alpha;
      gamma_r <= cfg_gamma;
    end
  end

  // Stages S1..S3; alpha is snapshotted at acceptance so in-flight results ignore later writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
      s1_r <= '0;
      s2_r <= '0;
      s3_r <= '0;
      r1_r <= {DATA_WIDTH{1'b0}};
      a1_r <= {DATA_WIDTH{1'b0}};
      a2_r <= {DATA_WIDTH{1'b0}};
    end else if (en_s) begin
      v1_r <= i_valid;
      v2_r <= v1_r;
      v3_r <= v2_r;
      s1_r <= s1_s;
      s2_r <= s2_s;
      s3_r <= s3_s;
      r1_r <= i_rt;
      a1_r <= alpha_r;
      a2_r <= a1_r;
    end
  end

  // Output register S4; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_q_new <= {DATA_WIDTH{1'b0}};
      o_id    <= {ID_WIDTH{1'b0}};
      o_sat   <= 1'b0;
    end else if (en_s) begin
      o_valid <= v3_r;
      o_q_new <= qn_s[DATA_WIDTH-1:0];
      o_id    <= s3_r.id;
      o_sat   <= s3_r.sat | qn_s[DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_q_update_pipe.sv
// Scoreboard bench for q_update_pipe: a 64-bit arithmetic reference model predicts
// each accepted transaction; a negedge monitor checks results, order, holds and latency.
`timescale 1ns/1ps
module tb_q_update_pipe;
  import q_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_alpha = 32'h0, cfg_gamma = 32'h0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [7:0]  i_id = 8'h0;
  logic [31:0] i_q = 32'h0, i_max_q = 32'h0, i_rt = 32'h0;
  logic        i_done = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic [7:0]  o_id;
  logic [31:0] o_q_new;
  logic        o_sat;

  q_update_pipe dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_alpha(cfg_alpha), .cfg_gamma(cfg_gamma),
    .i_valid(i_valid), .i_ready(i_ready), .i_id(i_id), .i_q(i_q), .i_max_q(i_max_q),
    .i_rt(i_rt), .i_done(i_done), .o_valid(o_valid), .o_ready(o_ready), .o_id(o_id),
    .o_q_new(o_q_new), .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [7:0]  id;
    logic        sat;
    bit          lat_chk;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur, nxt;
  int          n_cmp = 0, n_fail = 0, cyc = 0;
  longint      m_alpha, m_gamma, gm, td, dl, qn;
  bit          m_sat, head_seen = 1'b0, hold_v = 1'b0;
  logic [31:0] hold_q;
  logic [7:0]  hold_id;
  logic        hold_sat;
  bit          kat_en = 1'b0;
  logic [31:0] kat_q;
  logic        kat_sat;
  bit          rnd_on = 1'b0;

  localparam longint MAXV = longint'($signed(SAT_MAX));
  localparam longint MINV = longint'($signed(SAT_MIN));

  function automatic longint sx32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clampv(input longint v, inout bit s);
    if (v > MAXV) begin s = 1'b1; return MAXV; end
    if (v < MINV) begin s = 1'b1; return MINV; end
    return v;
  endfunction

  // Real-valued a*b/65536 rounded half up (floor of x+0.5), then clamped.
  function automatic longint fmul(input longint a, input longint b, inout bit s);
    return clampv((a * b + 64'sd32768) >>> 16, s);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor and model: check the output first, then predict any transaction accepted at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_alpha = sx32(Q_ALPHA_RST);
      m_gamma = sx32(Q_GAMMA_RST);
      hold_v = 1'b0;
      head_seen = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_q_new", o_q_new, hold_q);
        chk("hold_id", o_id, hold_id);
        chk("hold_sat", o_sat, hold_sat);
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("stray_output", o_valid, 0);
        end else begin
          cur = exp_q[0];
          chk("q_new", o_q_new, cur.q);
          chk("id", o_id, cur.id);
          chk("sat", o_sat, cur.sat);
          if (cur.lat_chk && !head_seen) chk("latency", cyc - cur.cyc, 4);
          head_seen = 1'b1;
          if (o_ready) begin
            void'(exp_q.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      hold_v = o_valid && !o_ready;
      if (hold_v) begin
        chk("i_ready_stall", i_ready, 0);
        hold_q = o_q_new;
        hold_id = o_id;
        hold_sat = o_sat;
      end
      if (i_valid && i_ready) begin
        m_sat = 1'b0;
        gm = i_done ? 64'sd0 : fmul(m_gamma, sx32(i_max_q), m_sat);
        td = clampv(sx32(i_rt) + gm - sx32(i_q), m_sat);
        dl = fmul(m_alpha, td, m_sat);
        qn = clampv(sx32(i_q) + dl, m_sat);
        nxt.id = i_id;
        nxt.cyc = cyc;
        nxt.lat_chk = kat_en;
        nxt.q = kat_en ? kat_q : qn[31:0];
        nxt.sat = kat_en ? kat_sat : m_sat;
        exp_q.push_back(nxt);
      end
      if (cfg_we) begin
        m_alpha = sx32(cfg_alpha);
        m_gamma = sx32(cfg_gamma);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] id, input logic [31:0] q, input logic [31:0] mq,
                      input logic [31:0] rt, input logic done);
    int t = 0;
    i_valid = 1'b1; i_id = id; i_q = q; i_max_q = mq; i_rt = rt; i_done = done;
    @(negedge clk);
    while (!i_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!i_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: i_ready stuck 0 for id %0h", id);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    kat_en = 1'b0;
  endtask

  task automatic send_kat(input logic [7:0] id, input logic [31:0] q, input logic [31:0] mq,
                          input logic [31:0] rt, input logic done, input logic [31:0] kq,
                          input logic ks);
    kat_en = 1'b1; kat_q = kq; kat_sat = ks;
    send(id, q, mq, rt, done);
  endtask

  task automatic write_cfg(input logic [31:0] a, input logic [31:0] g);
    cfg_we = 1'b1; cfg_alpha = a; cfg_gamma = g;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = $urandom;
      1: v = 32'h7FFF_FFFF;
      2: v = 32'h8000_0000;
      default: v = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_q_new", o_q_new, 0);
    chk("rst_o_id", o_id, 0);
    chk("rst_o_sat", o_sat, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_i_ready", i_ready, 1);

    send_kat(8'h11, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 32'h0001_A666, 1'b0);
    send_kat(8'h12, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b1, 32'h0000_C000, 1'b0);
    drain();

    write_cfg(32'h0001_0000, Q_GAMMA_RST);
    send_kat(8'h13, 32'h9000_0000, 32'h0000_0000, 32'h7000_0000, 1'b0, 32'h0FFF_FFFF, 1'b1);
    drain();
    write_cfg(32'h0000_8000, Q_GAMMA_RST);

    // Config write in the same cycle as A only affects B.
    cfg_we = 1'b1; cfg_alpha = 32'h0000_4000; cfg_gamma = Q_GAMMA_RST;
    send_kat(8'hA0, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 32'h0001_A666, 1'b0);
    cfg_we = 1'b0;
    send_kat(8'hB0, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 32'h0001_5333, 1'b0);
    drain();

    fork
      begin
        for (int k = 0; k < 8; k++)
          send(8'h20 + 8'(k), 32'h0001_0000 + 32'(k) * 32'h0000_4000, 32'h0002_0000, 32'h0000_8000, 1'(k & 1));
      end
      begin
        repeat (5) @(posedge clk);
        #1 o_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 o_ready = 1'b1;
      end
    join
    drain();

    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          if ($urandom_range(0, 9) == 0) begin
            cfg_we = 1'b1;
            cfg_alpha = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h0001_0000));
            cfg_gamma = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h0001_0000));
          end
          send(8'($urandom), rnd_val(), rnd_val(), rnd_val(), 1'($urandom_range(0, 3) == 0));
          cfg_we = 1'b0;
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          o_ready = ($urandom_range(0, 3) != 0);
        end
        o_ready = 1'b1;
      end
    join
    drain();

    // Mid-flight reset after non-default config: everything in flight is discarded.
    write_cfg(32'h0000_4000, 32'h0001_0000);
    for (int k = 0; k < 3; k++)
      send(8'h70 + 8'(k), rnd_val(), rnd_val(), rnd_val(), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_q_new", o_q_new, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_i_ready", i_ready, 1);
    send_kat(8'h5A, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 32'h0001_A666, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
